// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial wide add/subtract sequencer driving a shared external 8-bit adder slice.
// Operands are processed LSB byte first, one byte per clock, with the carry held between bytes.
module byte_serial_add_ctrl #(
  parameter int NUM_BYTES = 4,
  localparam int W = 8 * NUM_BYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_sub,
  output logic [7:0]   add_a,
  output logic [7:0]   add_b,
  output logic         add_cin,
  input  logic [7:0]   add_s,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         busy
);

  localparam int IDX_W = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             carry_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     sum_reg;
  logic             cout_reg;
  logic             ovf_reg;

  logic [7:0] a_bytes [NUM_BYTES];
  logic [7:0] b_bytes [NUM_BYTES];

  // Byte views of the latched operands so the slice mux is a plain array select.
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_bytes
    assign a_bytes[gi] = a_reg[8*gi +: 8];
    assign b_bytes[gi] = b_reg[8*gi +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            // Subtract is A + ~B + 1; the forced carry completes the two's complement.
            a_reg     <= in_a;
            b_reg     <= in_sub ? ~in_b : in_b;
            carry_reg <= in_sub ? 1'b1 : in_cin;
            idx_reg   <= '0;
            state_reg <= ADD;
          end
        end
        ADD: begin
          sum_reg[8*idx_reg +: 8] <= add_s;
          carry_reg               <= add_cout;
          if (idx_reg == LAST_IDX) begin
            cout_reg  <= add_cout;
            ovf_reg   <= (a_reg[W-1] == b_reg[W-1]) && (add_s[7] != a_reg[W-1]);
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    add_a   = 8'd0;
    add_b   = 8'd0;
    add_cin = 1'b0;
    if (state_reg == ADD) begin
      add_a   = a_bytes[idx_reg];
      add_b   = b_bytes[idx_reg];
      add_cin = carry_reg;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign out_sum   = sum_reg;
  assign out_cout  = cout_reg;
  assign out_ovf   = ovf_reg;

endmodule
